pattern_scan_ctrl: RTL
======================

# pattern_scan_ctrl

Programmable serial pattern-scan controller that sequences a single-bit stream through a run-time configured pattern matcher. Software-side logic loads a pattern, pattern length and scan length, pulses `start`, and the block accepts exactly that many bits over a valid/ready handshake. It flags every overlapping occurrence, counts matches and signals completion. This is the generalised, sequenced replacement for the fixed "101" Mealy detector, and it sits between the serial bit source and the status/interrupt logic.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (2..16).
- `LEN_W`, 4: width of `cfg_len`; must hold `PAT_W`.
- `SCAN_W`, 16: width of the scan-length counter.
- `CNT_W`, 8: width of the match counter.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `aresetn`  in  1  reset, **synchronous, active-low**.
- `cfg_pattern`  in  PAT_W  pattern; bit `cfg_len-1` is expected first, bit 0 last.
- `cfg_len`  in  LEN_W  pattern length, legal range 1..PAT_W.
- `cfg_bits`  in  SCAN_W  number of stream bits to scan, legal range ≥1.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `bit_valid`  in  1  stream bit available.
- `bit_in`  in  1  stream bit.
- `bit_ready`  out  1  block accepts a bit this cycle.
- `busy`  out  1  scan in progress.
- `match`  out  1  registered one-cycle pulse: pattern just completed.
- `match_count`  out  CNT_W  matches in the current/last scan; saturating.
- `done`  out  1  one-cycle pulse: scan complete.
- `cfg_err`  out  1  one-cycle pulse: `start` rejected.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE + `start`, legal config:** latch `cfg_pattern`, `cfg_len`, `cfg_bits`. Clear the history register, fill counter and `match_count`. Go to RUN.
- **IDLE + `start`, illegal config** (`cfg_len`==0, `cfg_len`>PAT_W, or `cfg_bits`==0): pulse `cfg_err` the next cycle and stay in IDLE. `match_count` is not cleared.
- **RUN:**
  - `bit_ready`=1. A bit is accepted when `bit_valid & bit_ready`.
  - On accept: `hist <= {hist[PAT_W-2:0], bit_in}`; fill counter increments and saturates at PAT_W; remaining-bits counter decrements.
  - Match condition uses the post-shift history: `fill >= len` and `hist[len-1:0] == pattern[len-1:0]`.
  - On a match, `match` pulses and `match_count` increments, saturating at 2^CNT_W-1.
  - Overlapping matches are counted. History is never cleared on a match.
  - When the last bit is accepted, go to DONE.
- **DONE:** `done`=1 for one cycle, `bit_ready`=0, then return to IDLE. `match_count` holds until the next legal `start`.
- `start` during RUN or DONE is ignored, with no error.
- Config inputs are don't-care outside the `start` cycle in IDLE.

## Timing
- Reset (synchronous, `aresetn`=0 at an edge): state IDLE, all counters and history at 0, `bit_ready`/`busy`/`match`/`done`/`cfg_err`=0, `match_count`=0. Reset overrides everything, including mid-RUN: the scan is aborted with no `done`.
- `start` at edge N → `busy`=1, `bit_ready`=1 from cycle N+1.
- A bit accepted at edge K that completes the pattern → `match`=1 during cycle K+1.
- The last bit accepted at edge K → state DONE and `done`=1 during K+1. `match` for that bit also fires in K+1. `busy`=1 through DONE and drops in K+2.
- `busy` = (state != IDLE). `bit_ready` = (state == RUN), with no dependency on `bit_valid`.
- `bit_valid` low stalls the scan indefinitely with no timeout. Bubbles do not reset the history.
- Minimum scan duration: `cfg_bits`+2 cycles from `start`. Back-to-back: the next `start` is accepted in the cycle after DONE.

## Structure
- Package `pattern_scan_pkg`:
  - state enum `{S_IDLE, S_RUN, S_DONE}`
  - default width localparams
  - function `len_mask(len)` returning a PAT_W mask of the low `len` bits.
- One natural sub-module: `pattern_window_cmp`, combinational. It takes `hist`, `pattern`, `len` and `fill`, and returns `hit`. The controller holds the FSM, counters and handshake.

## Test plan
- Pattern 101 (`cfg_pattern`=8'b101, `cfg_len`=3), `cfg_bits`=9, stream 1,0,1,0,1,0,0,1,1 with `bit_valid` always high → `match` after bits 3 and 5, `match_count`=2, `done` one cycle after bit 9.
- `cfg_len`=2, pattern 11, stream of eight 1s → 7 overlapping matches, `match_count`=7.
- `cfg_len`=0, then `cfg_len`=9 (PAT_W=8), then `cfg_bits`=0 → three `cfg_err` pulses, `busy` stays 0, prior `match_count` is retained.
- Pattern 101 with `bit_valid` toggling every other cycle, same bits as the first scenario → identical match positions by bit index and `match_count`=2. No bit is accepted while `bit_valid`=0.
- `aresetn` low for one cycle after 4 accepted bits → all outputs 0 the next cycle, no `done`. A fresh `start` then behaves like a clean scan.
- CNT_W=2, pattern 1 (`cfg_len`=1), 6 ones → `match_count` saturates at 3, while `match` still pulses 6 times.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared state type, default widths and mask helper for the pattern scanner
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } scan_state_e;

  localparam int PAT_W_DEF  = 8;
  localparam int LEN_W_DEF  = 4;
  localparam int SCAN_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;
  localparam int PAT_W_MAX  = 16;

  // Mask of the low len bits, wide enough for the largest supported pattern.
  function automatic logic [PAT_W_MAX-1:0] len_mask(input int unsigned len);
    logic [PAT_W_MAX-1:0] m;
    if (len >= PAT_W_MAX) m = '1;
    else                  m = (PAT_W_MAX'(1) << len) - PAT_W_MAX'(1);
    return m;
  endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// rtl/pattern_window_cmp.sv - compares the low len bits of the history window against the pattern
module pattern_window_cmp
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic [PAT_W-1:0] hist,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] fill,
  output logic             hit
);

  logic [PAT_W-1:0] mask;

  always_comb begin
    mask = PAT_W'(len_mask(32'(len)));
    // fill guards against matching on zeros left over from the clear
    hit  = (fill >= len) && (((hist ^ pattern) & mask) == '0);
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - sequenced serial pattern scanner: config latch, bit handshake, match counting
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W  = PAT_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int SCAN_W = SCAN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [SCAN_W-1:0] cfg_bits,
  input  logic              start,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              done,
  output logic              cfg_err
);

  scan_state_e       state_q, state_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  fill_q, fill_d;
  logic [SCAN_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              match_q, match_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [PAT_W-1:0]  hist_shift;
  logic [LEN_W-1:0]  fill_inc;
  logic              cfg_ok;
  logic              hit;

  // Candidate post-accept window; the comparator judges the bit being accepted now.
  assign hist_shift = {hist_q[PAT_W-2:0], bit_in};
  assign fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
  assign cfg_ok     = (cfg_len != '0) && (32'(cfg_len) <= PAT_W) && (cfg_bits != '0);

  pattern_window_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .hist    (hist_shift),
    .pattern (pat_q),
    .len     (len_q),
    .fill    (fill_inc),
    .hit     (hit)
  );

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    pat_d    = pat_q;
    len_d    = len_q;
    fill_d   = fill_q;
    remain_d = remain_q;
    count_d  = count_q;
    match_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d  = S_RUN;
            pat_d    = cfg_pattern;
            len_d    = cfg_len;
            remain_d = cfg_bits;
            hist_d   = '0;
            fill_d   = '0;
            count_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bit_valid) begin
          hist_d   = hist_shift;
          fill_d   = fill_inc;
          remain_d = remain_q - SCAN_W'(1);
          match_d  = hit;
          if (hit && (count_q != '1)) count_d = count_q + CNT_W'(1);
          if (remain_q == SCAN_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      hist_q   <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      remain_q <= '0;
      count_q  <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      remain_q <= remain_d;
      count_q  <= count_d;
      match_q  <= match_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bit_ready   = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign match       = match_q;
  assign match_count = count_q;
  assign done        = done_q;
  assign cfg_err     = err_q;

endmodule
